// File: rtl/ssad_scan_ctrl_if.sv
// ---------------------------------------------------------------------------
// ssad_scan_ctrl_if
//   Bundles the command, SAD-pipe handshake and min-register strobe signals
//   of the SSAD scan sequencer.
//   master : the sequencer (drives status, SAD request and min strobes)
//   slave  : the surrounding core / datapath (drives start, abort,
//            frame_base and sad_ack)
//   Signals:
//     start, abort, frame_base    command from the core
//     busy, done                  scan status
//     sad_req, sad_addr,
//     sad_b_valid, sad_ack        request/acknowledge to the SAD compute pipe
//     min_clear, min_in,
//     window_shift, frame_shift   min-register update strobes
//     load_min, result_valid,
//     result_kind                 result readback control
// ---------------------------------------------------------------------------
interface ssad_scan_ctrl_if;
    logic        start;
    logic        abort;
    logic [31:0] frame_base;
    logic        busy;
    logic        done;
    logic        sad_req;
    logic [31:0] sad_addr;
    logic        sad_b_valid;
    logic        sad_ack;
    logic        min_clear;
    logic        min_in;
    logic        window_shift;
    logic        frame_shift;
    logic        load_min;
    logic        result_valid;
    logic        result_kind;

    modport master (
        input  start, abort, frame_base, sad_ack,
        output busy, done, sad_req, sad_addr, sad_b_valid,
               min_clear, min_in, window_shift, frame_shift,
               load_min, result_valid, result_kind
    );

    modport slave (
        output start, abort, frame_base, sad_ack,
        input  busy, done, sad_req, sad_addr, sad_b_valid,
               min_clear, min_in, window_shift, frame_shift,
               load_min, result_valid, result_kind
    );
endinterface

// File: rtl/ssad_scan_ctrl.sv
// ---------------------------------------------------------------------------
// ssad_scan_ctrl
//   Sequencer for the SSAD minimum-search datapath. Walks every candidate
//   window of a frame two vertically adjacent rows at a time, requests the
//   SAD of each pair, strobes the min register on each returned pair and
//   finally reads back the best SAD and its tag (winning address).
//   Ports:
//     Clk    rising-edge clock
//     Reset  asynchronous, active-low reset
//     bus    ssad_scan_ctrl_if.master (command, SAD handshake, min strobes,
//            readback control)
//   Parameters:
//     COLS, ROWS              candidate grid size (odd ROWS -> half pair)
//     COL_STRIDE, ROW_STRIDE  address step per column / per row
// ---------------------------------------------------------------------------
module ssad_scan_ctrl #(
    parameter int COLS       = 64,
    parameter int ROWS       = 64,
    parameter int COL_STRIDE = 4,
    parameter int ROW_STRIDE = 256
) (
    input logic               Clk,
    input logic               Reset,
    ssad_scan_ctrl_if.master  bus
);

    localparam int PAIR_ROWS = (ROWS + 1) / 2;
    localparam int COL_W     = $clog2(COLS + 1);
    localparam int ROWP_W    = $clog2(PAIR_ROWS + 1);

    localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(COLS - 1);
    localparam logic [ROWP_W-1:0] ROWP_LAST  = ROWP_W'(PAIR_ROWS - 1);
    // Row pairs whose lower row (2*rowp+1) is still inside the frame.
    localparam logic [ROWP_W-1:0] FULL_PAIRS = ROWP_W'(ROWS / 2);
    localparam logic [31:0]       COL_STEP   = 32'(COL_STRIDE);
    localparam logic [31:0]       PAIR_STEP  = 32'(2 * ROW_STRIDE);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ISSUE,
        WAIT,
        UPDATE,
        RD_MIN,
        RD_TAG,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [ROWP_W-1:0]   rowp_q, rowp_d;
    logic [31:0]         row_addr_q, row_addr_d;   // address of (0, 2*rowp)
    logic [31:0]         addr_q, addr_d;
    logic                bval_q, bval_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                clr_q, clr_d;
    logic                min_in_q, min_in_d;
    logic                ws_q, ws_d;
    logic                fs_q, fs_d;
    logic                kind_q, kind_d;
    logic                last_pair;

    function automatic logic b_valid_of(input logic [ROWP_W-1:0] rowp);
        return rowp < FULL_PAIRS;
    endfunction

    assign last_pair = (col_q == COL_LAST) && (rowp_q == ROWP_LAST);

    // Next state and next value of every registered output. Registered
    // strobes are computed from the state being entered so they are valid
    // for exactly the cycle spent in that state.
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        rowp_d     = rowp_q;
        row_addr_d = row_addr_q;
        addr_d     = addr_q;
        bval_d     = bval_q;
        done_d     = 1'b0;
        clr_d      = 1'b0;
        min_in_d   = 1'b0;
        ws_d       = 1'b0;
        fs_d       = 1'b0;
        kind_d     = 1'b0;

        if (bus.abort && (state_q != IDLE)) begin
            // Abort wins over everything, including a same-cycle sad_ack.
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_d    = CLEAR;
                        row_addr_d = bus.frame_base;
                        col_d      = '0;
                        rowp_d     = '0;
                        clr_d      = 1'b1;
                    end
                end
                CLEAR: begin
                    state_d = ISSUE;
                    addr_d  = row_addr_q;
                    bval_d  = b_valid_of(rowp_q);
                end
                ISSUE: begin
                    // An ack here belongs to no request and is dropped.
                    state_d = WAIT;
                end
                WAIT: begin
                    if (bus.sad_ack) begin
                        state_d  = UPDATE;
                        min_in_d = 1'b1;
                        if (col_q != COL_LAST) begin
                            ws_d = 1'b1;
                        end else begin
                            fs_d = 1'b1;
                        end
                    end
                end
                UPDATE: begin
                    if (col_q != COL_LAST) begin
                        col_d = col_q + 1'b1;
                    end else begin
                        col_d  = '0;
                        rowp_d = rowp_q + 1'b1;
                    end
                    if (last_pair) begin
                        // sad_addr keeps the final pair's address.
                        state_d = RD_MIN;
                    end else begin
                        state_d = ISSUE;
                        if (col_q != COL_LAST) begin
                            addr_d = addr_q + COL_STEP;
                        end else begin
                            row_addr_d = row_addr_q + PAIR_STEP;
                            addr_d     = row_addr_q + PAIR_STEP;
                        end
                        bval_d = b_valid_of(rowp_d);
                    end
                end
                RD_MIN: begin
                    state_d = RD_TAG;
                    kind_d  = 1'b1;
                end
                RD_TAG: begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    // State and registered-output stage
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= IDLE;
            col_q      <= '0;
            rowp_q     <= '0;
            row_addr_q <= '0;
            addr_q     <= '0;
            bval_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            clr_q      <= 1'b0;
            min_in_q   <= 1'b0;
            ws_q       <= 1'b0;
            fs_q       <= 1'b0;
            kind_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            rowp_q     <= rowp_d;
            row_addr_q <= row_addr_d;
            addr_q     <= addr_d;
            bval_q     <= bval_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            clr_q      <= clr_d;
            min_in_q   <= min_in_d;
            ws_q       <= ws_d;
            fs_q       <= fs_d;
            kind_q     <= kind_d;
        end
    end

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.sad_addr     = addr_q;
    assign bus.sad_b_valid  = bval_q;
    assign bus.min_clear    = clr_q;
    assign bus.min_in       = min_in_q;
    assign bus.window_shift = ws_q;
    assign bus.frame_shift  = fs_q;
    assign bus.result_kind  = kind_q;

    // Decoded straight from state so they track the state register exactly.
    assign bus.sad_req      = (state_q == ISSUE) || (state_q == WAIT);
    assign bus.load_min     = (state_q == RD_MIN);
    assign bus.result_valid = (state_q == RD_MIN) || (state_q == RD_TAG);

endmodule

// File: tb/tb_ssad_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ssad_scan_ctrl
//   Four sequencer instances with different grid shapes and strides share
//   one clock and reset. For each scan the bench builds the expected list of
//   candidate pairs (address, B validity, shift kind) directly from the
//   scan rules and walks the DUT through it with random ack delays.
// ---------------------------------------------------------------------------
module tb_ssad_scan_ctrl;
    localparam int N = 4;
    localparam int CFG_COLS [N] = '{3, 2, 1, 4};
    localparam int CFG_ROWS [N] = '{4, 5, 1, 7};
    localparam int CFG_CS   [N] = '{4, 8, 4, 12};
    localparam int CFG_RS   [N] = '{256, 100, 256, 64};

    localparam logic [31:0] M_BUSY = 32'h200;
    localparam logic [31:0] M_DONE = 32'h100;
    localparam logic [31:0] M_REQ  = 32'h080;
    localparam logic [31:0] M_CLR  = 32'h040;
    localparam logic [31:0] M_MIN  = 32'h020;
    localparam logic [31:0] M_WS   = 32'h010;
    localparam logic [31:0] M_FS   = 32'h008;
    localparam logic [31:0] M_LD   = 32'h004;
    localparam logic [31:0] M_RV   = 32'h002;
    localparam logic [31:0] M_KIND = 32'h001;

    typedef struct packed {
        logic [31:0] addr;
        logic        bval;
        logic        frame;
    } pair_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start_v [N];
    logic        abort_v [N];
    logic        ack_v   [N];
    logic [31:0] base_v  [N];

    logic        busy_o [N], done_o [N], req_o [N], bval_o [N], clr_o [N];
    logic        min_in_o [N], ws_o [N], fs_o [N], ld_o [N], rv_o [N], kind_o [N];
    logic [31:0] addr_o [N];

    int ncmp = 0;
    int nfail = 0;

    for (genvar g = 0; g < N; g++) begin : g_dut
        ssad_scan_ctrl_if bus ();
        assign bus.start      = start_v[g];
        assign bus.abort      = abort_v[g];
        assign bus.sad_ack    = ack_v[g];
        assign bus.frame_base = base_v[g];
        assign busy_o[g]   = bus.busy;
        assign done_o[g]   = bus.done;
        assign req_o[g]    = bus.sad_req;
        assign addr_o[g]   = bus.sad_addr;
        assign bval_o[g]   = bus.sad_b_valid;
        assign clr_o[g]    = bus.min_clear;
        assign min_in_o[g] = bus.min_in;
        assign ws_o[g]     = bus.window_shift;
        assign fs_o[g]     = bus.frame_shift;
        assign ld_o[g]     = bus.load_min;
        assign rv_o[g]     = bus.result_valid;
        assign kind_o[g]   = bus.result_kind;

        ssad_scan_ctrl #(
            .COLS       (CFG_COLS[g]),
            .ROWS       (CFG_ROWS[g]),
            .COL_STRIDE (CFG_CS[g]),
            .ROW_STRIDE (CFG_RS[g])
        ) u_dut (
            .Clk   (clk),
            .Reset (rst_n),
            .bus   (bus)
        );
    end

    function automatic logic [31:0] ctl(input int k);
        return {22'd0, busy_o[k], done_o[k], req_o[k], clr_o[k], min_in_o[k],
                ws_o[k], fs_o[k], ld_o[k], rv_o[k], kind_o[k]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    // One complete scan on instance k. first_wait >= 0 forces the ack delay
    // of the first pair; other pairs use 0..max_wait cycles.
    task automatic run_scan(input int k, input logic [31:0] base,
                            input int max_wait, input int first_wait);
        pair_t q[$];
        pair_t p;
        int    nrp;
        int    nws;
        int    nfs;
        int    d;
        nrp = (CFG_ROWS[k] + 1) / 2;
        nws = 0;
        nfs = 0;
        for (int rp = 0; rp < nrp; rp++) begin
            for (int c = 0; c < CFG_COLS[k]; c++) begin
                p.addr  = base + 32'(c * CFG_CS[k]) + 32'(2 * rp * CFG_RS[k]);
                p.bval  = (2 * rp + 1 < CFG_ROWS[k]);
                p.frame = (c == CFG_COLS[k] - 1);
                q.push_back(p);
            end
        end

        base_v[k]  = base;
        start_v[k] = 1'b1;
        tick;
        start_v[k] = 1'b0;
        check("clear", ctl(k), M_BUSY | M_CLR);
        tick;
        for (int i = 0; i < q.size(); i++) begin
            check("issue_ctl", ctl(k), M_BUSY | M_REQ);
            check("issue_addr", addr_o[k], q[i].addr);
            check("issue_bval", 32'(bval_o[k]), 32'(q[i].bval));
            ack_v[k] = ($urandom_range(0, 2) == 0);   // stray ack in ISSUE
            tick;
            ack_v[k] = 1'b0;
            d = (i == 0 && first_wait >= 0) ? first_wait : int'($urandom_range(0, max_wait));
            for (int j = 0; j < d; j++) begin
                check("wait_ctl", ctl(k), M_BUSY | M_REQ);
                check("wait_addr", addr_o[k], q[i].addr);
                start_v[k] = $urandom_range(0, 1);   // start while busy
                tick;
            end
            start_v[k] = 1'b0;
            check("wait_ctl", ctl(k), M_BUSY | M_REQ);
            ack_v[k] = 1'b1;
            tick;
            ack_v[k] = 1'b0;
            check("update_ctl", ctl(k), M_BUSY | M_MIN | (q[i].frame ? M_FS : M_WS));
            check("update_addr", addr_o[k], q[i].addr);
            if (ws_o[k]) nws++;
            if (fs_o[k]) nfs++;
            tick;
        end
        check("rd_min", ctl(k), M_BUSY | M_LD | M_RV);
        tick;
        check("rd_tag", ctl(k), M_BUSY | M_RV | M_KIND);
        tick;
        check("done", ctl(k), M_BUSY | M_DONE);
        tick;
        check("idle", ctl(k), 32'h0);
        check("n_window", 32'(nws), 32'((CFG_COLS[k] - 1) * nrp));
        check("n_frame", 32'(nfs), 32'(nrp));
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            start_v[k] = 1'b0;
            abort_v[k] = 1'b0;
            ack_v[k]   = 1'b0;
            base_v[k]  = 32'h0;
        end
        rst_n = 1'b0;
        tick;
        tick;
        for (int k = 0; k < N; k++) begin
            check("reset_ctl", ctl(k), 32'h0);
            check("reset_addr", addr_o[k], 32'h0);
        end
        rst_n = 1'b1;
        tick;

        // 3x4 grid, ack right after each request; then a long first wait
        run_scan(0, 32'h0000_1000, 0, 0);
        run_scan(0, 32'h0000_1000, 3, 10);
        // odd row count leaves a half pair
        run_scan(1, $urandom, 3, -1);
        // single candidate
        run_scan(2, $urandom, 2, -1);
        // larger grid, random bases including 32-bit wrap
        run_scan(3, $urandom, 4, -1);
        run_scan(3, 32'hFFFF_FF80, 2, -1);

        // abort together with sad_ack in WAIT
        base_v[0]  = 32'h0000_2000;
        start_v[0] = 1'b1;
        tick;
        start_v[0] = 1'b0;
        tick;
        tick;
        check("abort_pre_wait", ctl(0), M_BUSY | M_REQ);
        ack_v[0]   = 1'b1;
        abort_v[0] = 1'b1;
        tick;
        ack_v[0]   = 1'b0;
        abort_v[0] = 1'b0;
        check("abort_ctl", ctl(0), 32'h0);
        tick;
        tick;
        check("abort_no_done", ctl(0), 32'h0);
        run_scan(0, $urandom, 2, -1);

        // abort during CLEAR
        start_v[3] = 1'b1;
        tick;
        start_v[3] = 1'b0;
        abort_v[3] = 1'b1;
        tick;
        abort_v[3] = 1'b0;
        check("abort_clear", ctl(3), 32'h0);

        // asynchronous reset in the middle of WAIT
        base_v[1]  = 32'h0000_3000;
        start_v[1] = 1'b1;
        tick;
        start_v[1] = 1'b0;
        tick;
        tick;
        check("rst_pre_wait", ctl(1), M_BUSY | M_REQ);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_ctl", ctl(1), 32'h0);
        check("rst_async_addr", addr_o[1], 32'h0);
        tick;
        rst_n = 1'b1;
        tick;
        check("rst_release", ctl(1), 32'h0);
        run_scan(1, $urandom, 3, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
